// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types: machine word, RAM port status and the
//            memory arbiter grant state.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM for the access currently presented to it.
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  // Which requester (if any) currently owns the RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISERV = 2'b01,
    DSERV = 2'b10
  } arb_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the fetch requester, data requester and RAM port
//            signals seen by the memory arbiter.
// Ports    : master - arbiter view (requests/RAM status in, waits/RAM cmds out)
//            slave  - environment view (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // instruction requester
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  // data requester
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  // RAM port
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  // status
  logic      bus_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           bus_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           bus_err
  );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between instruction fetch and data access.
//            Data has priority; a fetch that has watched MAX_DSTREAK data
//            grants in a row is served next. Accesses ending in RAM ERROR or
//            exceeding TIMEOUT_CYC service cycles are aborted and flagged on
//            the sticky bus_err output.
// Ports    : CLK  - clock
//            RST  - synchronous active-high reset
//            bus  - mem_arbiter_if.master (requesters, RAM port, bus_err)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  mem_arbiter_if.master      bus
);

  localparam int DSW = $clog2(MAX_DSTREAK + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t     state_q,   state_d;
  logic [DSW-1:0] dstreak_q, dstreak_d;
  logic [TCW-1:0] tcnt_q,    tcnt_d;
  logic           bus_err_q, bus_err_d;

  logic w_done;   // RAM finished the granted access this cycle
  logic w_abort;  // RAM failed or the access ran out of time

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      tcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      tcnt_q    <= tcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dstreak_d    = dstreak_q;
    tcnt_d       = tcnt_q;
    bus_err_d    = bus_err_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = bus.ramload;
    bus.dload    = bus.ramload;
    bus.bus_err  = bus_err_q;

    w_done  = (bus.ramstate == ACCESS);
    w_abort = !w_done &&
              ((bus.ramstate == ERROR) || (tcnt_q == TCW'(TIMEOUT_CYC - 1)));

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        // A fetch that has waited through a full data streak wins the tie.
        if ((bus.dREN || bus.dWEN) &&
            !(bus.iREN && (dstreak_q == DSW'(MAX_DSTREAK)))) begin
          state_d = DSERV;
        end else if (bus.iREN) begin
          state_d = ISERV;
        end
      end

      ISERV: begin
        if (!bus.iREN) begin
          // Requester gave up: release the port quietly.
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (w_done || w_abort) begin
            bus.iwait = 1'b0;
            state_d   = IDLE;
            tcnt_d    = '0;
            if (w_done) dstreak_d = '0;
            if (w_abort) bus_err_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end

      DSERV: begin
        if (!(bus.dREN || bus.dWEN)) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN && !bus.dWEN;  // write wins over read
          if (w_done || w_abort) begin
            bus.dwait = 1'b0;
            state_d   = IDLE;
            tcnt_d    = '0;
            if (w_abort) bus_err_d = 1'b1;
            // Streak only grows while a fetch is actually being held off.
            if (w_done) begin
              if (!bus.iREN) begin
                dstreak_d = '0;
              end else if (dstreak_q != DSW'(MAX_DSTREAK)) begin
                dstreak_d = dstreak_q + DSW'(1);
              end
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios followed
//            by random traffic compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXD = 4;
  localparam int TOUT = 64;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT_CYC(TOUT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (who owns the port, how long) ---------
  int    m_owner;   // 0 nobody, 1 fetch, 2 data
  int    m_streak;  // data wins in a row while fetch waited
  int    m_age;     // service cycles already spent on current grant
  bit    m_err;
  int    n_owner, n_streak, n_age;
  bit    n_err;
  logic  e_iwait, e_dwait, e_ren, e_wen, e_iload_ok, e_dload_ok;
  word_t e_addr, e_store;

  task automatic model_eval();
    bit finished, failed, holding;
    e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
    e_iload_ok = 0; e_dload_ok = 0; e_addr = '0; e_store = '0;
    n_owner = m_owner; n_streak = m_streak; n_age = m_age; n_err = m_err;
    finished = (bus.ramstate == ACCESS);
    failed   = !finished && (bus.ramstate == ERROR || m_age == TOUT - 1);
    if (m_owner == 0) begin
      n_age = 0;
      if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak >= MAXD)) n_owner = 2;
      else if (bus.iREN) n_owner = 1;
    end else begin
      holding = (m_owner == 1) ? bus.iREN : (bus.dREN || bus.dWEN);
      if (!holding) begin
        n_owner = 0; n_age = 0;
      end else begin
        if (m_owner == 1) begin
          e_ren = 1; e_addr = bus.iaddr;
        end else begin
          e_wen = bus.dWEN; e_ren = !bus.dWEN; e_addr = bus.daddr; e_store = bus.dstore;
        end
        if (finished || failed) begin
          n_owner = 0; n_age = 0;
          if (m_owner == 1) begin e_iwait = 0; e_iload_ok = finished; end
          else              begin e_dwait = 0; e_dload_ok = finished; end
          if (failed) n_err = 1;
          if (finished) begin
            if (m_owner == 1)     n_streak = 0;
            else if (bus.iREN)    n_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
            else                  n_streak = 0;
          end
        end else begin
          n_age = m_age + 1;
        end
      end
    end
    if (rst) begin n_owner = 0; n_streak = 0; n_age = 0; n_err = 0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle_check();
    #4;
    model_eval();
    if (chk_en) begin
      chk("iwait",   {31'b0, bus.iwait},   {31'b0, e_iwait});
      chk("dwait",   {31'b0, bus.dwait},   {31'b0, e_dwait});
      chk("ramREN",  {31'b0, bus.ramREN},  {31'b0, e_ren});
      chk("ramWEN",  {31'b0, bus.ramWEN},  {31'b0, e_wen});
      chk("bus_err", {31'b0, bus.bus_err}, {31'b0, m_err});
      chk("one_en",  {31'b0, bus.ramREN & bus.ramWEN}, 32'b0);
      if (e_ren || e_wen) chk("ramaddr", bus.ramaddr, e_addr);
      if (e_wen)          chk("ramstore", bus.ramstore, e_store);
      if (e_iload_ok)     chk("iload", bus.iload, bus.ramload);
      if (e_dload_ok)     chk("dload", bus.dload, bus.ramload);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_owner = n_owner; m_streak = n_streak; m_age = n_age; m_err = n_err;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  initial begin
    string seq;
    int    n;
    bit    idone, ddone;
    int    kind;

    rst = 1;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    m_owner = 0; m_streak = 0; m_age = 0; m_err = 0;
    #1;
    cycle();
    rst = 0;
    chk_en = 1;
    // reset state
    settle_check();
    chk("rst_iwait", {31'b0, bus.iwait}, 32'd1);
    chk("rst_err",   {31'b0, bus.bus_err}, 32'd0);
    advance();

    // ---- instruction read alone, ACCESS on third service cycle ----
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    settle_check();
    chk("t1_idle_ren", {31'b0, bus.ramREN}, 32'd0);
    advance();
    for (int k = 1; k <= 3; k++) begin
      bus.ramstate = (k == 3) ? ACCESS : BUSY;
      bus.ramload  = (k == 3) ? 32'h2008000A : $urandom;
      settle_check();
      chk("t1_ren",   {31'b0, bus.ramREN}, 32'd1);
      chk("t1_addr",  bus.ramaddr, 32'h40);
      chk("t1_iwait", {31'b0, bus.iwait}, (k == 3) ? 32'd0 : 32'd1);
      if (k == 3) chk("t1_iload", bus.iload, 32'h2008000A);
      advance();
    end
    bus.iREN = 0; bus.ramstate = FREE;
    cycle();

    // ---- simultaneous requests: data first, then fetch ----
    bus.iREN = 1; bus.iaddr = 32'h44;
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
    bus.ramstate = ACCESS;
    cycle();
    settle_check();
    chk("t2_wen",   {31'b0, bus.ramWEN}, 32'd1);
    chk("t2_addr",  bus.ramaddr, 32'h100);
    chk("t2_dwait", {31'b0, bus.dwait}, 32'd0);
    chk("t2_iwait", {31'b0, bus.iwait}, 32'd1);
    advance();
    bus.dWEN = 0;
    settle_check();
    chk("t2_idle", {31'b0, bus.ramREN | bus.ramWEN}, 32'd0);
    advance();
    settle_check();
    chk("t2_iserv", bus.ramaddr, 32'h44);
    chk("t2_idone", {31'b0, bus.iwait}, 32'd0);
    advance();
    bus.iREN = 0;
    cycle();

    // ---- starvation guard ----
    bus.iREN = 1; bus.dREN = 1; bus.daddr = 32'h200; bus.ramstate = ACCESS;
    seq = "";
    for (int k = 0; k < 12; k++) begin
      settle_check();
      if (bus.dwait === 1'b0) seq = {seq, "D"};
      if (bus.iwait === 1'b0) seq = {seq, "I"};
      advance();
    end
    checks++;
    assert (seq == "DDDDID") else begin
      failures++;
      $error("FAIL t3_order observed=%s expected=DDDDID", seq);
    end
    bus.iREN = 0; bus.dREN = 0;
    cycle();

    // ---- ERROR abort on fetch ----
    bus.iREN = 1; bus.ramstate = ERROR;
    cycle();
    settle_check();
    chk("t5_iwait", {31'b0, bus.iwait}, 32'd0);
    chk("t5_err0",  {31'b0, bus.bus_err}, 32'd0);
    advance();
    bus.iREN = 0;
    settle_check();
    chk("t5_err1", {31'b0, bus.bus_err}, 32'd1);
    chk("t5_idle", {31'b0, bus.ramREN}, 32'd0);
    advance();

    // reset clears the sticky flag
    rst = 1;
    cycle();
    rst = 0;
    settle_check();
    chk("rst_clr", {31'b0, bus.bus_err}, 32'd0);
    advance();

    // ---- timeout on data read ----
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    cycle();
    n = 1;
    while (n <= 100) begin
      settle_check();
      if (bus.dwait === 1'b0) break;
      advance();
      n++;
    end
    chk("t4_cycle", n, TOUT);
    advance();
    bus.dREN = 0;
    for (int k = 0; k < 3; k++) begin
      settle_check();
      chk("t4_sticky", {31'b0, bus.bus_err}, 32'd1);
      advance();
    end

    // ---- reset in the middle of a data access ----
    bus.dREN = 1; bus.daddr = 32'h304;
    cycle();
    rst = 1;
    cycle();
    rst = 0; bus.ramstate = ACCESS;
    settle_check();
    chk("t6_ren",   {31'b0, bus.ramREN}, 32'd0);
    chk("t6_dwait", {31'b0, bus.dwait}, 32'd1);
    chk("t6_err",   {31'b0, bus.bus_err}, 32'd0);
    advance();
    bus.dREN = 0;
    cycle();

    // ---- random traffic against the model ----
    idone = 0; ddone = 0;
    for (int k = 0; k < 3000; k++) begin
      if (idone || $urandom_range(0, 49) == 0) bus.iREN = 0;
      else if (!bus.iREN && $urandom_range(0, 3) == 0) begin
        bus.iREN = 1; bus.iaddr = $urandom;
      end
      if (ddone || $urandom_range(0, 49) == 0) begin
        bus.dREN = 0; bus.dWEN = 0;
      end else if (!(bus.dREN || bus.dWEN) && $urandom_range(0, 3) == 0) begin
        kind = $urandom_range(0, 2);
        bus.dREN = (kind != 1); bus.dWEN = (kind != 0);
        bus.daddr = $urandom; bus.dstore = $urandom;
      end
      n = $urandom_range(0, 19);
      bus.ramstate = (n < 8) ? ACCESS : (n < 16 || n == 19) ? BUSY : (n < 18) ? FREE : ERROR;
      bus.ramload = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      settle_check();
      idone = !e_iwait;
      ddone = !e_dwait;
      advance();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data requester.
- The data requester is the one whose dmemREN/dmemWEN/imemREN are produced by the request unit.
- Grants one requester at a time through a registered FSM, drives the RAM port from the granted requester, and returns wait/load data.
- Data requests get priority, bounded by a starvation guard for fetch. Failed or hung RAM accesses are aborted and reported on a sticky error flag.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT_CYC, 64: cycles a granted access may wait for ACCESS before abort.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address (word_t)
- iwait  out  1  instruction wait; 0 for exactly the completion cycle
- iload  out  32  instruction data; valid when iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data wait; 0 for exactly the completion cycle
- dload  out  32  data read value; valid when dwait=0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- bus_err  out  1  sticky error flag; set on RAM ERROR or timeout; cleared only by RST

Behaviour:
- Reset:
  - Reset is synchronous, active-high on CLK. RST has priority over everything, including an in-flight access.
  - RST forces state=IDLE, dstreak=0, tcnt=0, bus_err=0.
  - Registered state and counters reset synchronously. ramREN/ramWEN/iwait/dwait are decoded from state and RAM inputs, so they become 0/0/1/1 in the cycle after RST is sampled.
- States: IDLE, ISERV, DSERV.
- IDLE:
  - Drives ramREN=ramWEN=0, iwait=dwait=1.
  - Next state is DSERV if (dREN|dWEN) and !(iREN and dstreak==MAX_DSTREAK).
  - Otherwise ISERV if iREN; otherwise stay in IDLE.
  - Minimum latency, request to completion: 2 cycles (1 arbitration cycle in IDLE, then at least 1 service cycle).
- ISERV:
  - Drives ramREN=1, ramaddr=iaddr, ramWEN=0.
- DSERV:
  - Drives ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
  - If both dREN and dWEN are set, the write wins.
- Completion (in a serve state, ramstate==ACCESS):
  - The granted wait goes to 0 combinationally in that cycle.
  - iload/dload = ramload; they are don't-care otherwise.
  - Next state is IDLE; tcnt resets to 0.
- Abort on RAM error (ramstate==ERROR):
  - Granted wait goes to 0 that cycle; bus_err is set next cycle; next state is IDLE.
- Abort on timeout:
  - tcnt increments each serve cycle without ACCESS.
  - When tcnt==TIMEOUT_CYC-1 and ramstate is not ACCESS: behave as an ERROR abort (wait=0, bus_err set, IDLE).
- Request withdrawn mid-service (granted request deasserts):
  - RAM enables drop combinationally; next state is IDLE.
  - Wait stays 1; bus_err is not set.
- Starvation counter dstreak:
  - On DSERV completion: if iREN=1, dstreak increments, saturating at MAX_DSTREAK; if iREN=0, dstreak goes to 0.
  - On ISERV completion: dstreak goes to 0.
- Non-granted requester: its wait is always 1. Requesters hold address, data and enables stable until their wait drops.
- Only one RAM enable is ever active per cycle.

Decomposition:
- cpu_types_pkg holds word_t and ramstate_t. Add arb_state_t (IDLE, ISERV, DSERV) to the same package.
- No sub-module is needed. Counters and FSM live in one module with an always_ff for registers and an always_comb for next-state logic and outputs.

Test Plan:
- Instruction read alone: iREN=1, iaddr=0x40, RAM returns ACCESS on the 3rd service cycle with ramload=0x2008000A.
  → iwait=0 in exactly that cycle, iload=0x2008000A, ramREN=1 for 3 cycles, 4 cycles total.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD) in IDLE, ACCESS after 1 cycle.
  → DSERV first with ramWEN=1, ramaddr=0x100; then IDLE; then ISERV.
- Starvation guard, MAX_DSTREAK=4: dREN and iREN held continuously, RAM always ACCESS.
  → 4 data completions, then 1 instruction completion, then data resumes; dstreak returns to 0.
- Timeout: DSERV, ramstate held BUSY.
  → at cycle TIMEOUT_CYC (64) dwait=0 and ramREN falls; bus_err=1 next cycle and stays set until RST.
- ERROR abort: ISERV, ramstate=ERROR.
  → iwait=0 that cycle, bus_err=1 next cycle, state IDLE.
- Reset mid-access: RST=1 during DSERV with ramstate BUSY.
  → next cycle ramREN=ramWEN=0, iwait=dwait=1, bus_err=0, state IDLE; no completion pulse is emitted.
